// File: rtl/sc_reg_dispatch_1_2_3.sv
// rtl/sc_reg_dispatch_1_2_3.sv - captures one word and loads it in order into up to three destination registers
// Optional busy-wait timeout per destination: define SC_REGDISPATCH_TIMEOUT_EN.
module sc_reg_dispatch_1_2_3 #(
  parameter int RegDISPATCH_DATAWIDTH = 8,
  parameter int RegDISPATCH_TIMEOUT   = 16
) (
  input  logic                             SC_RegDISPATCH_CLOCK_50,
  input  logic                             SC_RegDISPATCH_RESET_InHigh,
  input  logic                             SC_RegDISPATCH_start_InLow,
  input  logic                             SC_RegDISPATCH_abort_InHigh,
  input  logic [2:0]                       SC_RegDISPATCH_mask_InBUS,
  input  logic [RegDISPATCH_DATAWIDTH-1:0] SC_RegDISPATCH_data_InBUS,
  input  logic [2:0]                       SC_RegDISPATCH_destBusy_InBUS,
  output logic [RegDISPATCH_DATAWIDTH-1:0] SC_RegDISPATCH_data_OutBUS1,
  output logic [RegDISPATCH_DATAWIDTH-1:0] SC_RegDISPATCH_data_OutBUS2,
  output logic [RegDISPATCH_DATAWIDTH-1:0] SC_RegDISPATCH_data_OutBUS3,
  output logic                             SC_RegDISPATCH_load_OutLow1,
  output logic                             SC_RegDISPATCH_load_OutLow2,
  output logic                             SC_RegDISPATCH_load_OutLow3,
  output logic                             SC_RegDISPATCH_busy_OutHigh,
  output logic                             SC_RegDISPATCH_done_OutHigh,
  output logic [2:0]                       SC_RegDISPATCH_err_OutBUS
);

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, SEND3, DONE} state_t;

  state_t                           state, state_d;
  logic [RegDISPATCH_DATAWIDTH-1:0] word_q;
  logic [2:0]                       mask_q;
  logic [2:0]                       sel;
  logic [2:0]                       above;
  logic [2:0]                       load_n;
  logic                             capture;

  // Lowest enabled destination in m, or DONE when nothing is left to send.
  function automatic state_t first_from(input logic [2:0] m);
    if (m[0])      return SEND1;
    else if (m[1]) return SEND2;
    else if (m[2]) return SEND3;
    else           return DONE;
  endfunction

  always_comb begin
    sel   = 3'b000;
    above = 3'b000;
    case (state)
      SEND1:   begin sel = 3'b001; above = 3'b110; end
      SEND2:   begin sel = 3'b010; above = 3'b100; end
      SEND3:   begin sel = 3'b100; above = 3'b000; end
      default: begin sel = 3'b000; above = 3'b000; end
    endcase
  end

`ifdef SC_REGDISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(RegDISPATCH_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic [2:0]    err_q;
  logic          tmo_hit;
`endif

  always_comb begin
    state_d = state;
    load_n  = 3'b111;
    capture = 1'b0;
`ifdef SC_REGDISPATCH_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!SC_RegDISPATCH_start_InLow) begin
          capture = 1'b1;
          state_d = first_from(SC_RegDISPATCH_mask_InBUS);
        end
      end
      SEND1, SEND2, SEND3: begin
        if (!(|(SC_RegDISPATCH_destBusy_InBUS & sel))) begin
          load_n  = ~sel;
          state_d = first_from(mask_q & above);
        end
`ifdef SC_REGDISPATCH_TIMEOUT_EN
        else if (cnt_q == CW'(RegDISPATCH_TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = first_from(mask_q & above);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a start sampled in IDLE.
    if (SC_RegDISPATCH_abort_InHigh) begin
      state_d = IDLE;
      load_n  = 3'b111;
      capture = 1'b0;
`ifdef SC_REGDISPATCH_TIMEOUT_EN
      tmo_hit = 1'b0;
`endif
    end
  end

  always_ff @(posedge SC_RegDISPATCH_CLOCK_50) begin
    if (SC_RegDISPATCH_RESET_InHigh) begin
      state  <= IDLE;
      word_q <= '0;
      mask_q <= 3'b000;
    end else begin
      state <= state_d;
      if (capture) begin
        word_q <= SC_RegDISPATCH_data_InBUS;
        mask_q <= SC_RegDISPATCH_mask_InBUS;
      end
    end
  end

`ifdef SC_REGDISPATCH_TIMEOUT_EN
  // Counts consecutive busy cycles; any state change restarts it.
  always_ff @(posedge SC_RegDISPATCH_CLOCK_50) begin
    if (SC_RegDISPATCH_RESET_InHigh) begin
      cnt_q <= '0;
      err_q <= 3'b000;
    end else begin
      if (state_d != state || sel == 3'b000) cnt_q <= '0;
      else                                   cnt_q <= cnt_q + 1'b1;
      if (capture)      err_q <= 3'b000;
      else if (tmo_hit) err_q <= err_q | sel;
    end
  end
  assign SC_RegDISPATCH_err_OutBUS = err_q;
`else
  assign SC_RegDISPATCH_err_OutBUS = 3'b000;
`endif

  assign SC_RegDISPATCH_data_OutBUS1 = word_q;
  assign SC_RegDISPATCH_data_OutBUS2 = word_q;
  assign SC_RegDISPATCH_data_OutBUS3 = word_q;
  assign SC_RegDISPATCH_load_OutLow1 = load_n[0];
  assign SC_RegDISPATCH_load_OutLow2 = load_n[1];
  assign SC_RegDISPATCH_load_OutLow3 = load_n[2];
  assign SC_RegDISPATCH_busy_OutHigh = (state != IDLE);
  assign SC_RegDISPATCH_done_OutHigh = (state == DONE);

endmodule

// File: doc/sc_reg_dispatch_1_2_3.md
Name: sc_reg_dispatch_1_2_3

Overview:
Write-side counterpart of the three-source general register. The general register merges three buses into one stored word; this block goes the other way. It captures one word and delivers it in order to up to three destination registers. Each destination is driven through its own data bus and an active-low load strobe, and the block waits on each destination's busy flag. It sits between a datapath result bus and the three destination registers. A controller FSM issues start and reads busy, done and error.

Parameters:
RegDISPATCH_DATAWIDTH, 8, width of the data word and all data buses
RegDISPATCH_TIMEOUT, 16, busy-wait limit in cycles per destination (used only when the optional feature is compiled in; minimum 2)

Ports:
SC_RegDISPATCH_CLOCK_50  in  1  system clock, all logic on rising edge
SC_RegDISPATCH_RESET_InHigh  in  1  reset, synchronous, active-high
SC_RegDISPATCH_start_InLow  in  1  start request, active-low, sampled only in IDLE
SC_RegDISPATCH_abort_InHigh  in  1  abort current dispatch, active-high
SC_RegDISPATCH_mask_InBUS  in  3  destination enable; bit0 = dest1, bit1 = dest2, bit2 = dest3
SC_RegDISPATCH_data_InBUS  in  DATAWIDTH  word to dispatch
SC_RegDISPATCH_destBusy_InBUS  in  3  per-destination busy; bit k-1 = dest k
SC_RegDISPATCH_data_OutBUS1/2/3  out  DATAWIDTH  captured word to dest 1/2/3
SC_RegDISPATCH_load_OutLow1/2/3  out  1  active-low load strobe to dest 1/2/3
SC_RegDISPATCH_busy_OutHigh  out  1  high in any state except IDLE
SC_RegDISPATCH_done_OutHigh  out  1  one-cycle pulse, high in DONE
SC_RegDISPATCH_err_OutBUS  out  3  per-destination timeout flags

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state = IDLE, captured word = 0, captured mask = 0, all data_OutBUS = 0, all load_OutLow = 1, busy = 0, done = 0, err = 0, timeout counter = 0.
- States: IDLE, SEND1, SEND2, SEND3, DONE.
- IDLE, start low on an edge:
  - capture data_InBUS and mask_InBUS;
  - clear err;
  - go to SENDk for the lowest set mask bit;
  - mask = 000 goes straight to DONE.
- Start while not in IDLE is ignored. A start held low in DONE or IDLE re-triggers on each IDLE edge; it is level-sampled, not edge-detected.
- data_OutBUS1/2/3 are registered copies of the captured word. They hold their value until the next accepted start or reset.
- SENDk strobe: load_OutLowk = 0 (combinational) while state == SENDk and destBusy[k-1] == 0. On that edge, move to the next set mask bit above k, or to DONE if none remain.
- SENDk with destBusy[k-1] == 1: no strobe, stay in SENDk.
- Exactly one strobe per enabled destination per dispatch. Strobes are never simultaneous and always go in ascending order 1, 2, 3.
- DONE lasts one cycle (done = 1), then returns to IDLE.
- Latency, mask 111 with no busy: start sampled at edge E0; strobes in cycles 1, 2, 3; done in cycle 4; IDLE at cycle 5.
- Abort high, any state: next edge goes to IDLE with no done pulse. Strobes are suppressed combinationally in the abort cycle. Captured word and err are retained.
- Abort and start on the same edge in IDLE: abort wins, the start is ignored.
- Reset mid-dispatch: all outputs return to reset values on the next edge.
- destBusy bits for disabled destinations are ignored.

Optional Feature:
Macro SC_REGDISPATCH_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive busy cycles in SENDk.
  - When the count reaches RegDISPATCH_TIMEOUT with destBusy still high, dest k is skipped without a strobe.
  - err[k-1] is set and the FSM advances as for a normal strobe.
  - The counter clears on every state change.
  - err is sticky until the next accepted start or reset.
- Not defined: the counter logic is absent, SENDk waits indefinitely, and err_OutBUS is tied to 000.

Test Plan:
1. Reset high 2 cycles, then low -> all load_OutLow = 1, data_OutBUS = 0x00, busy = 0, done = 0, err = 000.
2. data = 0xA5, mask = 111, no busy, start low for 1 cycle -> load1/2/3 low in cycles 1, 2, 3; all data_OutBUS = 0xA5; done high in cycle 4 only; busy high in cycles 1-4.
3. data = 0x3C, mask = 101, destBusy[2] = 1 for 5 cycles -> load1 in cycle 1; load3 low in the first cycle destBusy[2] = 0; load2 never low; single done pulse.
4. mask = 000, start -> no strobes, done in cycle 1. Start during SEND2 of a mask-111 dispatch -> ignored, captured word unchanged.
5. Abort high in SEND2 while dest2 not busy -> load2 stays 1, IDLE next cycle, no done. Reset asserted in SEND3 -> reset values next edge.
6. With SC_REGDISPATCH_TIMEOUT_EN, TIMEOUT = 4, mask = 010, destBusy[1] held 1 -> no load2; after 4 busy cycles err = 010, then done. Without the macro, the same stimulus leaves the FSM in SEND2 and err = 000.
